// File: rtl/wb_trap_ctrl_pkg.sv
// Shared constants and types for the write-back trap controller: exception flag
// layout, cause codes, mtval source selection and the handshake FSM states.
package wb_trap_ctrl_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned EXCP_W   = 10;
  localparam int unsigned CODE_W   = 5;

  // wb_excp_i bit positions
  localparam int unsigned EX_PC_MISALIGN = 0;
  localparam int unsigned EX_IF_BUS_ERR  = 1;
  localparam int unsigned EX_ILEGL       = 2;
  localparam int unsigned EX_ECALL       = 3;
  localparam int unsigned EX_EBREAK      = 4;
  localparam int unsigned EX_LD_MISALIGN = 5;
  localparam int unsigned EX_LD_BUS_ERR  = 6;
  localparam int unsigned EX_ST_MISALIGN = 7;
  localparam int unsigned EX_ST_BUS_ERR  = 8;
  localparam int unsigned EX_RSVD        = 9;

  // Exception cause codes
  localparam logic [CODE_W-1:0] CAUSE_PC_MISALIGN = 5'd0;
  localparam logic [CODE_W-1:0] CAUSE_IF_BUS_ERR  = 5'd1;
  localparam logic [CODE_W-1:0] CAUSE_ILEGL       = 5'd2;
  localparam logic [CODE_W-1:0] CAUSE_EBREAK      = 5'd3;
  localparam logic [CODE_W-1:0] CAUSE_LD_MISALIGN = 5'd4;
  localparam logic [CODE_W-1:0] CAUSE_LD_BUS_ERR  = 5'd5;
  localparam logic [CODE_W-1:0] CAUSE_ST_MISALIGN = 5'd6;
  localparam logic [CODE_W-1:0] CAUSE_ST_BUS_ERR  = 5'd7;
  localparam logic [CODE_W-1:0] CAUSE_ECALL       = 5'd11;

  // Interrupt cause codes; local line i uses CAUSE_LCL_BASE + i
  localparam logic [CODE_W-1:0] CAUSE_MSI      = 5'd3;
  localparam logic [CODE_W-1:0] CAUSE_MTI      = 5'd7;
  localparam logic [CODE_W-1:0] CAUSE_MEI      = 5'd11;
  localparam int unsigned       CAUSE_LCL_BASE = 16;

  // Registered irq vector layout: {lcl, mei, mti, msi}
  localparam int unsigned IRQ_MSI     = 0;
  localparam int unsigned IRQ_MTI     = 1;
  localparam int unsigned IRQ_MEI     = 2;
  localparam int unsigned IRQ_LCL_LSB = 3;

  typedef enum logic [0:0] {StIdle, StFlush} trap_state_e;

  typedef enum logic [1:0] {TvalZero, TvalInstr, TvalAddr, TvalPc} tval_src_e;

  function automatic tval_src_e excp_tval_src(input logic [CODE_W-1:0] code);
    tval_src_e src;
    case (code)
      CAUSE_ILEGL:                        src = TvalInstr;
      CAUSE_IF_BUS_ERR, CAUSE_EBREAK:     src = TvalPc;
      CAUSE_PC_MISALIGN, CAUSE_LD_MISALIGN, CAUSE_LD_BUS_ERR,
      CAUSE_ST_MISALIGN, CAUSE_ST_BUS_ERR: src = TvalAddr;
      default:                            src = TvalZero;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/wb_trap_ctrl_prio_enc.sv
// Fixed-priority encoder selecting exactly one trap cause from the enabled interrupt
// vector and the WB exception flags; interrupts always win over exceptions.
module trap_prio_enc
  import wb_trap_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LCL_IRQ = 4
) (
  input  logic [IRQ_LCL_LSB+NUM_LCL_IRQ-1:0] irq_i,
  input  logic [EXCP_W-1:0]                  excp_i,
  output logic                               valid_o,
  output logic                               is_irq_o,
  output logic [CODE_W-1:0]                  code_o
);

  always_comb begin
    valid_o  = 1'b1;
    is_irq_o = 1'b1;
    code_o   = '0;
    if (irq_i[IRQ_MEI]) begin
      code_o = CAUSE_MEI;
    end else if (irq_i[IRQ_MSI]) begin
      code_o = CAUSE_MSI;
    end else if (irq_i[IRQ_MTI]) begin
      code_o = CAUSE_MTI;
    end else if (|irq_i[IRQ_LCL_LSB +: NUM_LCL_IRQ]) begin
      // Walk downwards so the lowest pending index is the last one written
      for (int i = int'(NUM_LCL_IRQ) - 1; i >= 0; i--) begin
        if (irq_i[IRQ_LCL_LSB+i]) begin
          code_o = CODE_W'(CAUSE_LCL_BASE) + CODE_W'(i);
        end
      end
    end else begin
      is_irq_o = 1'b0;
      if (excp_i[EX_IF_BUS_ERR]) begin
        code_o = CAUSE_IF_BUS_ERR;
      end else if (excp_i[EX_ILEGL]) begin
        code_o = CAUSE_ILEGL;
      end else if (excp_i[EX_PC_MISALIGN]) begin
        code_o = CAUSE_PC_MISALIGN;
      end else if (excp_i[EX_ECALL]) begin
        code_o = CAUSE_ECALL;
      end else if (excp_i[EX_EBREAK]) begin
        code_o = CAUSE_EBREAK;
      end else if (excp_i[EX_ST_MISALIGN]) begin
        code_o = CAUSE_ST_MISALIGN;
      end else if (excp_i[EX_LD_MISALIGN]) begin
        code_o = CAUSE_LD_MISALIGN;
      end else if (excp_i[EX_ST_BUS_ERR]) begin
        code_o = CAUSE_ST_BUS_ERR;
      end else if (excp_i[EX_LD_BUS_ERR]) begin
        code_o = CAUSE_LD_BUS_ERR;
      end else begin
        valid_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_trap_ctrl.sv
// Write-back trap controller: picks one trap or mret for the WB instruction, writes the
// trap CSRs and holds a registered redirect request until the pipeline controller accepts it.
module wb_trap_ctrl
  import wb_trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned NUM_LCL_IRQ = 4,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wb_valid_i,
  input  logic [XLEN-1:0]        wb_pc_i,
  input  logic [31:0]            wb_instr_i,
  input  logic [XLEN-1:0]        wb_alu_res_i,
  input  logic [EXCP_W-1:0]      wb_excp_i,
  input  logic                   wb_mret_i,
  input  logic                   irq_msi_i,
  input  logic                   irq_mti_i,
  input  logic                   irq_mei_i,
  input  logic [NUM_LCL_IRQ-1:0] irq_lcl_i,
  input  logic                   mstatus_mie_i,
  input  logic [XLEN-1:0]        mie_i,
  input  logic [XLEN-1:0]        mtvec_i,
  input  logic [XLEN-1:0]        mepc_i,
  output logic                   wb_kill_o,
  output logic                   mcause_wen_o,
  output logic                   mtval_wen_o,
  output logic                   mepc_wen_o,
  output logic [XLEN-1:0]        mcause_wdata_o,
  output logic [XLEN-1:0]        mtval_wdata_o,
  output logic [XLEN-1:0]        mepc_wdata_o,
  output logic                   trap_enter_o,
  output logic                   mret_commit_o,
  output logic                   flush_req_o,
  output logic [XLEN-1:0]        flush_pc_o,
  input  logic                   flush_ack_i,
  output logic                   wb_stall_o
);

  localparam int unsigned IrqW = IRQ_LCL_LSB + NUM_LCL_IRQ;

  trap_state_e     state_q;
  logic [IrqW-1:0] irq_q;
  logic [IrqW-1:0] mie_sel;
  logic [IrqW-1:0] irq_en;
  logic            flush_req_q;
  logic [XLEN-1:0] flush_pc_q;

  logic              enc_valid;
  logic              enc_is_irq;
  logic [CODE_W-1:0] enc_code;

  logic            take;
  logic            trap;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] target;

  // Only the enable bits matching implemented causes matter; rsvd flag is ignored
  logic unused_bits;
  assign unused_bits = ^{mie_i, wb_excp_i[EX_RSVD]};

  always_comb begin
    mie_sel          = '0;
    mie_sel[IRQ_MSI] = mie_i[CAUSE_MSI];
    mie_sel[IRQ_MTI] = mie_i[CAUSE_MTI];
    mie_sel[IRQ_MEI] = mie_i[CAUSE_MEI];
    for (int i = 0; i < int'(NUM_LCL_IRQ); i++) begin
      mie_sel[IRQ_LCL_LSB+i] = mie_i[int'(CAUSE_LCL_BASE)+i];
    end
  end

  assign irq_en = irq_q & mie_sel & {IrqW{mstatus_mie_i}};

  trap_prio_enc #(
    .NUM_LCL_IRQ(NUM_LCL_IRQ)
  ) u_prio_enc (
    .irq_i   (irq_en),
    .excp_i  (wb_excp_i),
    .valid_o (enc_valid),
    .is_irq_o(enc_is_irq),
    .code_o  (enc_code)
  );

  assign take = wb_valid_i && (state_q == StIdle) && (enc_valid || wb_mret_i);
  assign trap = take && enc_valid;

  assign wb_kill_o     = take;
  assign mcause_wen_o  = trap;
  assign mtval_wen_o   = trap;
  assign mepc_wen_o    = trap;
  assign trap_enter_o  = trap;
  assign mret_commit_o = take && !enc_valid;
  assign mepc_wdata_o  = wb_pc_i;

  always_comb begin
    mcause_wdata_o               = '0;
    mcause_wdata_o[XLEN-1]       = enc_is_irq;
    mcause_wdata_o[CODE_W-1:0]   = enc_code;
  end

  always_comb begin
    mtval_wdata_o = '0;
    if (!enc_is_irq) begin
      case (excp_tval_src(enc_code))
        TvalInstr: mtval_wdata_o = {{(XLEN-32){1'b0}}, wb_instr_i};
        TvalAddr:  mtval_wdata_o = wb_alu_res_i;
        TvalPc:    mtval_wdata_o = wb_pc_i;
        default:   mtval_wdata_o = '0;
      endcase
    end
  end

  assign base = {mtvec_i[XLEN-1:2], 2'b00};

  always_comb begin
    target = base;
    if (!enc_valid) begin
      target = mepc_i;
    end else if (enc_is_irq && VECTORED_EN && (mtvec_i[1:0] == 2'b01)) begin
      target = base + {{(XLEN-CODE_W-2){1'b0}}, enc_code, 2'b00};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      irq_q       <= '0;
      flush_req_q <= 1'b0;
      flush_pc_q  <= '0;
    end else begin
      irq_q <= {irq_lcl_i, irq_mei_i, irq_mti_i, irq_msi_i};
      case (state_q)
        StIdle: begin
          if (take) begin
            flush_req_q <= 1'b1;
            flush_pc_q  <= target;
            state_q     <= StFlush;
          end
        end
        StFlush: begin
          if (flush_ack_i) begin
            flush_req_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          flush_req_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign flush_req_o = flush_req_q;
  assign flush_pc_o  = flush_pc_q;
  assign wb_stall_o  = (state_q == StFlush);

endmodule

// File: tb/tb_wb_trap_ctrl.sv
// Directed bench for wb_trap_ctrl: vector table for single-trap arbitration plus
// hand-written handshake and reset sequences.
module tb_wb_trap_ctrl;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NL   = 4;

  logic            clk;
  logic            rst_n;
  logic            wb_valid;
  logic [XLEN-1:0] wb_pc;
  logic [31:0]     wb_instr;
  logic [XLEN-1:0] wb_alu;
  logic [9:0]      wb_excp;
  logic            wb_mret;
  logic            msi, mti, mei;
  logic [NL-1:0]   lcl;
  logic            gie;
  logic [XLEN-1:0] mie, mtvec, mepc;
  logic            ack;

  logic            kill, mcause_wen, mtval_wen, mepc_wen, trap_enter, mret_commit;
  logic [XLEN-1:0] mcause_wd, mtval_wd, mepc_wd, flush_pc;
  logic            flush_req, stall;

  logic            d_kill, d_mcause_wen, d_mtval_wen, d_mepc_wen, d_trap_enter, d_mret_commit;
  logic [XLEN-1:0] d_mcause_wd, d_mtval_wd, d_mepc_wd, d_flush_pc;
  logic            d_flush_req, d_stall;

  int errors = 0;
  int checks = 0;

  wb_trap_ctrl #(.XLEN(XLEN), .NUM_LCL_IRQ(NL), .VECTORED_EN(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb_valid_i(wb_valid), .wb_pc_i(wb_pc),
    .wb_instr_i(wb_instr), .wb_alu_res_i(wb_alu), .wb_excp_i(wb_excp), .wb_mret_i(wb_mret),
    .irq_msi_i(msi), .irq_mti_i(mti), .irq_mei_i(mei), .irq_lcl_i(lcl),
    .mstatus_mie_i(gie), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
    .wb_kill_o(kill), .mcause_wen_o(mcause_wen), .mtval_wen_o(mtval_wen),
    .mepc_wen_o(mepc_wen), .mcause_wdata_o(mcause_wd), .mtval_wdata_o(mtval_wd),
    .mepc_wdata_o(mepc_wd), .trap_enter_o(trap_enter), .mret_commit_o(mret_commit),
    .flush_req_o(flush_req), .flush_pc_o(flush_pc), .flush_ack_i(ack), .wb_stall_o(stall)
  );

  wb_trap_ctrl #(.XLEN(XLEN), .NUM_LCL_IRQ(NL), .VECTORED_EN(1'b0)) dut_d (
    .clk_i(clk), .rst_n_i(rst_n), .wb_valid_i(wb_valid), .wb_pc_i(wb_pc),
    .wb_instr_i(wb_instr), .wb_alu_res_i(wb_alu), .wb_excp_i(wb_excp), .wb_mret_i(wb_mret),
    .irq_msi_i(msi), .irq_mti_i(mti), .irq_mei_i(mei), .irq_lcl_i(lcl),
    .mstatus_mie_i(gie), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
    .wb_kill_o(d_kill), .mcause_wen_o(d_mcause_wen), .mtval_wen_o(d_mtval_wen),
    .mepc_wen_o(d_mepc_wen), .mcause_wdata_o(d_mcause_wd), .mtval_wdata_o(d_mtval_wd),
    .mepc_wdata_o(d_mepc_wd), .trap_enter_o(d_trap_enter), .mret_commit_o(d_mret_commit),
    .flush_req_o(d_flush_req), .flush_pc_o(d_flush_pc), .flush_ack_i(ack),
    .wb_stall_o(d_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            valid;
    logic            msi, mti, mei;
    logic [NL-1:0]   lcl;
    logic            gie;
    logic [XLEN-1:0] mie, mtvec, mepc, pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] alu;
    logic [9:0]      excp;
    logic            mret;
    logic            exp_take, exp_trap;
    logic [XLEN-1:0] exp_mcause, exp_mtval, exp_fpc, exp_fpc_d;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_excp = '0; wb_mret = 1'b0;
    msi = 1'b0; mti = 1'b0; mei = 1'b0; lcl = '0; ack = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    msi = v.msi; mti = v.mti; mei = v.mei; lcl = v.lcl; gie = v.gie;
    mie = v.mie; mtvec = v.mtvec; mepc = v.mepc;
    wb_valid = 1'b0; wb_excp = '0; wb_mret = 1'b0;
    tick();
    wb_valid = v.valid; wb_pc = v.pc; wb_instr = v.instr; wb_alu = v.alu;
    wb_excp = v.excp; wb_mret = v.mret;
    #1;
    chk($sformatf("v%0d_kill", idx), 64'(kill), 64'(v.exp_take));
    chk($sformatf("v%0d_mcause_wen", idx), 64'(mcause_wen), 64'(v.exp_trap));
    chk($sformatf("v%0d_mtval_wen", idx), 64'(mtval_wen), 64'(v.exp_trap));
    chk($sformatf("v%0d_mepc_wen", idx), 64'(mepc_wen), 64'(v.exp_trap));
    chk($sformatf("v%0d_trap_enter", idx), 64'(trap_enter), 64'(v.exp_trap));
    chk($sformatf("v%0d_mret_commit", idx), 64'(mret_commit),
        64'(v.exp_take & ~v.exp_trap));
    if (v.exp_trap) begin
      chk($sformatf("v%0d_mcause", idx), mcause_wd, v.exp_mcause);
      chk($sformatf("v%0d_mtval", idx), mtval_wd, v.exp_mtval);
      chk($sformatf("v%0d_mepc", idx), mepc_wd, v.pc);
      chk($sformatf("v%0d_mcause_d", idx), d_mcause_wd, v.exp_mcause);
    end
    tick();
    wb_valid = 1'b0; wb_excp = '0; wb_mret = 1'b0;
    chk($sformatf("v%0d_flush_req", idx), 64'(flush_req), 64'(v.exp_take));
    chk($sformatf("v%0d_stall", idx), 64'(stall), 64'(v.exp_take));
    if (v.exp_take) begin
      chk($sformatf("v%0d_flush_pc", idx), flush_pc, v.exp_fpc);
      chk($sformatf("v%0d_flush_pc_d", idx), d_flush_pc, v.exp_fpc_d);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk($sformatf("v%0d_ack_idle", idx), 64'({flush_req, stall}), 64'(0));
    end
    idle_inputs();
  endtask

  initial begin
    // valid, msi,mti,mei, lcl, gie, mie, mtvec, mepc, pc, instr, alu, excp, mret,
    // exp_take, exp_trap, exp_mcause, exp_mtval, exp_fpc, exp_fpc_d
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 64'h100, 64'h0, 64'h8000_0010, 32'hFFFF_FFFF, 64'h1234, 10'h024, 1'b0, 1'b1, 1'b1, 64'h2, 64'hFFFF_FFFF, 64'h100, 64'h100};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 64'h880, 64'h201, 64'h0, 64'h8000_0100, 32'h13, 64'h0, 10'h000, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_000B, 64'h0, 64'h22C, 64'h200};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 64'h880, 64'h201, 64'h0, 64'h8000_0100, 32'h13, 64'h0, 10'h000, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 64'h100, 64'h8000_0040, 64'h8000_0200, 32'h3020_0073, 64'h0, 10'h000, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0, 64'h8000_0040, 64'h8000_0040};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 64'h201, 64'h0, 64'h100, 32'h73, 64'h99, 10'h018, 1'b0, 1'b1, 1'b1, 64'hB, 64'h0, 64'h200, 64'h200};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 64'h100, 64'h0, 64'h2000, 32'h0010_0073, 64'h3003, 10'h090, 1'b0, 1'b1, 1'b1, 64'h3, 64'h2000, 64'h100, 64'h100};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 64'h100, 64'h0, 64'h2100, 32'h0, 64'h4001, 10'h1A0, 1'b0, 1'b1, 1'b1, 64'h6, 64'h4001, 64'h100, 64'h100};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 64'h100, 64'h0, 64'h2200, 32'h0, 64'h5555, 10'h040, 1'b0, 1'b1, 1'b1, 64'h5, 64'h5555, 64'h100, 64'h100};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 64'h100, 64'h0, 64'h6000, 32'h0, 64'h6002, 10'h003, 1'b0, 1'b1, 1'b1, 64'h1, 64'h6000, 64'h100, 64'h100};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 64'h100, 64'h0, 64'h7000, 32'h0, 64'h7002, 10'h009, 1'b0, 1'b1, 1'b1, 64'h0, 64'h7002, 64'h100, 64'h100};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 64'h88, 64'h201, 64'h0, 64'h7100, 32'hFFFF_FFFF, 64'h0, 10'h004, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0003, 64'h0, 64'h20C, 64'h200};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 1'b1, 64'hC0000, 64'h301, 64'h0, 64'h7200, 32'h0, 64'h0, 10'h000, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0012, 64'h0, 64'h348, 64'h300};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 64'h800, 64'h201, 64'h0, 64'h7300, 32'h0, 64'h0, 10'h000, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 64'h100, 64'h0, 64'h7400, 32'h0, 64'h0, 10'h004, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 64'h800, 64'h203, 64'h0, 64'h7500, 32'h0, 64'h0, 10'h000, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_000B, 64'h0, 64'h200, 64'h200};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 64'h10800, 64'h201, 64'h0, 64'h7600, 32'h0, 64'h0, 10'h000, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_000B, 64'h0, 64'h22C, 64'h200};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 64'h100, 64'h0, 64'h7700, 32'h0, 64'h0, 10'h200, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 1'b1, 64'hA0000, 64'h401, 64'h0, 64'h7800, 32'h0, 64'h0, 10'h000, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0011, 64'h0, 64'h444, 64'h400};

    rst_n = 1'b0;
    idle_inputs();
    gie = 1'b0; mie = '0; mtvec = '0; mepc = '0;
    wb_pc = '0; wb_instr = '0; wb_alu = '0;
    tick();
    tick();
    chk("rst_flush_req", 64'(flush_req), 64'(0));
    chk("rst_flush_pc", flush_pc, 64'h0);
    chk("rst_stall", 64'(stall), 64'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Ack held low for five FLUSH cycles; later exceptions must be ignored
    gie = 1'b0; mie = '0; mtvec = 64'h100;
    tick();
    wb_valid = 1'b1; wb_excp = 10'h004; wb_pc = 64'h9000; wb_instr = 32'h13;
    #1;
    chk("hold_take_kill", 64'(kill), 64'(1));
    tick();
    wb_excp = 10'h008;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("hold%0d_req", c), 64'(flush_req), 64'(1));
      chk($sformatf("hold%0d_pc", c), flush_pc, 64'h100);
      chk($sformatf("hold%0d_stall", c), 64'(stall), 64'(1));
      chk($sformatf("hold%0d_kill", c), 64'({kill, mcause_wen, trap_enter}), 64'(0));
      tick();
    end
    ack = 1'b1;
    #1;
    chk("hold_ack_cycle_req", 64'(flush_req), 64'(1));
    tick();
    ack = 1'b0;
    #1;
    chk("hold_after_ack_stall", 64'(stall), 64'(0));
    chk("hold_after_ack_req", 64'(flush_req), 64'(0));
    chk("hold_retake_kill", 64'(kill), 64'(1));
    chk("hold_retake_mcause", mcause_wd, 64'hB);
    tick();
    chk("hold_retake_req", 64'(flush_req), 64'(1));
    wb_valid = 1'b0; wb_excp = '0; ack = 1'b1;
    tick();
    idle_inputs();

    // Interrupt drops during FLUSH; committed redirect must not change
    mei = 1'b1; gie = 1'b1; mie = 64'h800; mtvec = 64'h201;
    tick();
    wb_valid = 1'b1; wb_pc = 64'hA000;
    #1;
    chk("irqdrop_kill", 64'(kill), 64'(1));
    tick();
    wb_valid = 1'b0; mei = 1'b0;
    tick();
    tick();
    chk("irqdrop_req", 64'(flush_req), 64'(1));
    chk("irqdrop_pc", flush_pc, 64'h22C);
    ack = 1'b1;
    tick();
    tick();
    chk("ack_in_idle_req", 64'(flush_req), 64'(0));
    chk("ack_in_idle_stall", 64'(stall), 64'(0));
    idle_inputs();

    // Reset while in FLUSH abandons the request and clears the irq register
    mei = 1'b1; gie = 1'b1; mie = 64'h800; mtvec = 64'h201;
    tick();
    wb_valid = 1'b1; wb_pc = 64'hB000;
    #1;
    chk("rstfl_kill", 64'(kill), 64'(1));
    tick();
    chk("rstfl_req_pre", 64'(flush_req), 64'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rstfl_req", 64'(flush_req), 64'(0));
    chk("rstfl_stall", 64'(stall), 64'(0));
    chk("rstfl_irq_q_clear_kill", 64'(kill), 64'(0));
    tick();
    chk("rstfl_irq_resample_kill", 64'(kill), 64'(1));
    tick();
    wb_valid = 1'b0; ack = 1'b1;
    tick();
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_trap_ctrl.md
Name: wb_trap_ctrl

Overview:
Write-back-stage trap controller, parametrised successor of the combinational WB exception logic. Arbitrates the WB instruction's exceptions, mret and machine interrupts (MSI/MTI/MEI plus NUM_LCL_IRQ platform-local lines) with fixed priority. Computes mcause/mtval/mepc and a direct- or vectored-mode target PC. Drives a registered flush-request/ack handshake to the pipeline controller, stalling WB until the redirect is accepted.

Parameters:
XLEN, 64, datapath and CSR width
NUM_LCL_IRQ, 4, local interrupt lines, 1..16; cause codes 16..16+NUM_LCL_IRQ-1
VECTORED_EN, 1, 1 = honour mtvec.MODE=1 vectoring; 0 = always direct

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
wb_valid_i  in  1  valid instruction in WB this cycle
wb_pc_i  in  XLEN  WB instruction PC
wb_instr_i  in  32  WB instruction word
wb_alu_res_i  in  XLEN  WB address/ALU result
wb_excp_i  in  10  exception flags, bit order per package (pc_misalign, if_bus_err, ilegl, ecall, ebreak, ld_misalign, ld_bus_err, st_misalign, st_bus_err, rsvd)
wb_mret_i  in  1  WB instruction is mret
irq_msi_i / irq_mti_i / irq_mei_i  in  1 each  level machine interrupts
irq_lcl_i  in  NUM_LCL_IRQ  level local interrupts
mstatus_mie_i  in  1  global interrupt enable
mie_i  in  XLEN  per-cause enables (bit = cause code)
mtvec_i / mepc_i  in  XLEN  CSR values
wb_kill_o  out  1  suppress rd/CSR write of WB instruction (combinational)
mcause_wen_o, mtval_wen_o, mepc_wen_o  out  1  one-cycle CSR write strobes
mcause_wdata_o, mtval_wdata_o, mepc_wdata_o  out  XLEN  CSR write data
trap_enter_o  out  1  pulse: MPIE<=MIE, MIE<=0
mret_commit_o  out  1  pulse: MIE<=MPIE, MPIE<=1
flush_req_o  out  1  redirect request, registered
flush_pc_o  out  XLEN  redirect target, registered, stable while flush_req_o
flush_ack_i  in  1  controller accepts redirect
wb_stall_o  out  1  hold WB while not IDLE

Behaviour:
- Reset (rst_n_i=0 at posedge): state=IDLE, irq_q=0, flush_req_o=0, flush_pc_o=0, all strobes/pulses 0. Reset mid-FLUSH abandons the request.
- irq_q: one register stage sampling {irq_lcl_i, mei, mti, msi} every cycle in every state.
- States IDLE, FLUSH. wb_stall_o = (state==FLUSH).
- IDLE, wb_valid_i=1: take = irq_take | excp_any | wb_mret_i, where irq_take = mstatus_mie_i & |(irq_q & mie_i bits). On take: CSR strobes/pulses assert this cycle, wb_kill_o=1, target registered into flush_pc_o, flush_req_o=1 next cycle, state->FLUSH. wb_valid_i=0: nothing taken.
- Priority: interrupt > exception > mret. Interrupts: MEI(11) > MSI(3) > MTI(7) > lcl lowest index (16+i). Exceptions: if_bus_err(1) > ilegl(2) > pc_misalign(0) > ecall(11) > ebreak(3) > st_misalign(6) > ld_misalign(4) > st_bus_err(7) > ld_bus_err(5). Exactly one cause encoded (priority mux, no OR-mixing).
- mcause: interrupt {1'b1, zeros, code}; exception {1'b0, zeros, code}.
- mtval: ilegl -> zero-extended instr; ld/st misalign/bus_err, pc_misalign -> wb_alu_res_i; if_bus_err, ebreak -> wb_pc_i; ecall, interrupts -> 0.
- mepc = wb_pc_i for all traps (interrupted instruction killed, re-executed).
- mret (no irq/excp): no mcause/mtval/mepc write; mret_commit_o=1, trap_enter_o=0; target = mepc_i.
- Target: exception -> {mtvec_i[XLEN-1:2],2'b00}; interrupt with VECTORED_EN & mtvec_i[1:0]==1 -> base + 4*code (XLEN-bit add, wrap ignored); else base. mtvec MODE 2/3 treated as direct.
- FLUSH: flush_req_o held, flush_pc_o stable; no take evaluated, wb_kill_o=0, strobes 0. flush_ack_i=1 -> flush_req_o=0, state->IDLE next cycle; new take possible that next cycle. flush_ack_i in IDLE ignored.
- Interrupt deasserting during FLUSH has no effect on the committed trap.

Decomposition:
- Shared package: XLEN default, wb_excp_i bit indices, exception/interrupt cause code constants, state enum.
- Sub-module trap_prio_enc: combinational priority encoder (irq/excp vectors -> valid, is_irq, code); rest in top.

Test Plan:
- ilegl + ld_misalign together, pc=0x8000_0010, instr=0xFFFF_FFFF, mtvec=0x100 -> mcause=2, mtval=0xFFFF_FFFF, mepc=0x8000_0010, flush_pc=0x100, wb_kill=1.
- MTI+MEI pending, mie bits 7/11 set, MIE=1, mtvec=0x201 vectored -> mcause=0x8000_0000_0000_000B, flush_pc=0x22C; MIE=0 -> no trap.
- mret, mepc=0x8000_0040 -> only mret_commit pulse, flush_pc=0x8000_0040, no mcause/mtval/mepc strobe.
- Trap with flush_ack held low 5 cycles -> flush_req/flush_pc stable, wb_stall=1 for 5 cycles, new excp ignored; ack -> IDLE next cycle.
- Reset asserted in FLUSH -> next cycle flush_req=0, wb_stall=0, irq_q=0.
- lcl irq[2] with VECTORED_EN=0, mtvec=0x301 -> mcause code 18, flush_pc=0x300.
